// File: rtl/ko_4_mul_seq_ctrl_pkg.sv
// ko_4_mul_seq_ctrl_pkg: widths, FSM states, operand select and recombination coefficients for the KO-4 sequencer
package ko_4_mul_seq_ctrl_pkg;
  localparam int DATA_W = 72;
  localparam int KO_P   = 4;
  localparam int SEG_W  = DATA_W / KO_P;
  localparam int SUM_W  = SEG_W + 2;
  localparam int PROD_W = 2 * SUM_W;
  localparam int ACC_W  = 2 * DATA_W + 2;
  localparam int STEPS  = 9;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  // Issue order: p0, p1, p01, p2, p3, p23, p02, p13, p0123
  function automatic logic [SUM_W-1:0] ko_opnd(input logic [3:0] idx, input logic [DATA_W-1:0] x);
    logic [SUM_W-1:0] l0, l1, l2, l3, s02, s13;
    l0  = SUM_W'(x[SEG_W-1:0]);
    l1  = SUM_W'(x[2*SEG_W-1:SEG_W]);
    l2  = SUM_W'(x[3*SEG_W-1:2*SEG_W]);
    l3  = SUM_W'(x[4*SEG_W-1:3*SEG_W]);
    s02 = l0 + l2;
    s13 = l1 + l3;
    case (idx)
      4'd0:    ko_opnd = l0;
      4'd1:    ko_opnd = l1;
      4'd2:    ko_opnd = l0 + l1;
      4'd3:    ko_opnd = l2;
      4'd4:    ko_opnd = l3;
      4'd5:    ko_opnd = l2 + l3;
      4'd6:    ko_opnd = s02;
      4'd7:    ko_opnd = s13;
      4'd8:    ko_opnd = s02 + s13;
      default: ko_opnd = '0;
    endcase
  endfunction
  // Both recombination levels expanded into signed 18-bit-step shifts, modulo 2^ACC_W
  function automatic logic [ACC_W-1:0] ko_term(input logic [3:0] idx, input logic [PROD_W-1:0] p);
    logic [ACC_W-1:0] x;
    x = ACC_W'(p);
    case (idx)
      4'd0:    ko_term = x - (x << 18) - (x << 36) + (x << 54);
      4'd1:    ko_term = (x << 36) - (x << 18) - (x << 72) + (x << 54);
      4'd2:    ko_term = (x << 18) - (x << 54);
      4'd3:    ko_term = (x << 72) - (x << 36) - (x << 90) + (x << 54);
      4'd4:    ko_term = (x << 108) - (x << 72) - (x << 90) + (x << 54);
      4'd5:    ko_term = (x << 90) - (x << 54);
      4'd6:    ko_term = (x << 36) - (x << 54);
      4'd7:    ko_term = (x << 72) - (x << 54);
      4'd8:    ko_term = x << 54;
      default: ko_term = '0;
    endcase
  endfunction
endpackage

// File: rtl/ko_4_mul_seq_ctrl_seg_mul.sv
// ko_seg_mul: shared 20x20 unsigned multiplier with a registered 40-bit product
module ko_seg_mul
  import ko_4_mul_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SUM_W-1:0]  a,
  input  logic [SUM_W-1:0]  b,
  output logic [PROD_W-1:0] p
);
  logic [PROD_W-1:0] p_q, p_d;
  always_comb p_d = PROD_W'(a) * PROD_W'(b);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p_q <= '0;
    else p_q <= p_d;
  assign p = p_q;
endmodule

// File: rtl/ko_4_mul_seq_ctrl.sv
// ko_4_mul_seq_ctrl: iterative KO-4 72x72 multiplier, 9 sub-products on one shared multiplier.
// Define KO_ZERO_SKIP_EN to bypass the sub-product schedule when either operand is zero.
module ko_4_mul_seq_ctrl
  import ko_4_mul_seq_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] result,
  output logic                busy
);
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]    acc_q, acc_d, term;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic                skip_q, skip_d, skip;
  logic [SUM_W-1:0]    op_a, op_b;
  logic [PROD_W-1:0]   prod;
  ko_seg_mul u_mul (.clk(clk), .rst_n(rst_n), .a(op_a), .b(op_b), .p(prod));
  always_comb begin
`ifdef KO_ZERO_SKIP_EN
    skip = (A == '0) || (B == '0);
`else
    skip = 1'b0;
`endif
    op_a = ko_opnd(cnt_q, a_q);
    op_b = ko_opnd(cnt_q, b_q);
    // The registered product always belongs to the previously issued index
    term = ko_term(state_q == DRAIN ? 4'd8 : cnt_q - 4'd1, prod);
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    result_d = result_q;
    out_valid_d = out_valid_q;
    skip_d = skip_q;
    if (flush) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      acc_d = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_d = A;
          b_d = B;
          skip_d = skip;
          cnt_d = skip ? cnt_q : 4'd0;
          acc_d = skip ? acc_q : '0;
          state_d = skip ? DRAIN : ISSUE;
        end
        ISSUE: begin
          cnt_d = cnt_q + 4'd1;
          acc_d = cnt_q != 4'd0 ? acc_q + term : acc_q;
          state_d = cnt_q == 4'(STEPS - 1) ? DRAIN : ISSUE;
        end
        DRAIN: begin
          result_d = skip_q ? '0 : (2*DATA_W)'(acc_q + term);
          out_valid_d = 1'b1;
          state_d = DONE;
        end
        DONE: if (out_ready) begin
          out_valid_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      result_q <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      skip_q <= skip_d;
    end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ko_4_mul_seq_ctrl.sv
// tb_ko_4_mul_seq_ctrl: directed vector table, reset/flush sequences and random ops for ko_4_mul_seq_ctrl
module tb_ko_4_mul_seq_ctrl;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [71:0] a_in = 0, b_in = 0;
  logic in_ready, out_valid, busy;
  logic [143:0] result;
  int pass_cnt = 0, total = 0;
  typedef struct {
    logic [71:0]  a;
    logic [71:0]  b;
    logic [143:0] exp;
    int           hold;
    string        name;
  } vec_t;
  vec_t tv[7];

  ko_4_mul_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] mul(input logic [71:0] a, input logic [71:0] b);
    logic [143:0] x, y;
    x = {72'd0, a};
    y = {72'd0, b};
    return x * y;
  endfunction

  function automatic int lat_of(input logic [71:0] a, input logic [71:0] b);
`ifdef KO_ZERO_SKIP_EN
    return (a == 0 || b == 0) ? 1 : 10;
`else
    return 10;
`endif
  endfunction

  task automatic chk(input string nm, input logic [143:0] got, input logic [143:0] want);
    total++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  task automatic do_op(input logic [71:0] a, input logic [71:0] b, input logic [143:0] exp,
                       input int hold, input string nm);
    int n;
    logic [143:0] held;
    @(negedge clk);
    chk({nm, " in_ready before"}, 144'(in_ready), 144'd1);
    a_in = a;
    b_in = b;
    in_valid = 1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    a_in = {$urandom, $urandom, $urandom};
    b_in = {$urandom, $urandom, $urandom};
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 144'(n), 144'(lat_of(a, b)));
    chk({nm, " result"}, result, exp);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " held result"}, result, held);
      chk({nm, " held valid/ready"}, {142'd0, out_valid, in_ready}, 144'b10);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    chk({nm, " after handshake"}, {141'd0, out_valid, in_ready, busy}, 144'b010);
  endtask

  initial begin
    logic [71:0] ra, rb;
    int seen;
    tv[0] = '{72'd1, 72'd1, 144'd1, 0, "one_x_one"};
    tv[1] = '{{72{1'b1}}, {72{1'b1}}, {{71{1'b1}}, {72{1'b0}}, 1'b1}, 0, "max_x_max"};
    tv[2] = '{72'h123456789ABCDEF012, 72'hFEDCBA9876543210FE,
              mul(72'h123456789ABCDEF012, 72'hFEDCBA9876543210FE), 5, "hold5"};
    tv[3] = '{72'd1 << 71, 72'd2, 144'd1 << 72, 0, "top_bit_x2"};
    tv[4] = '{72'd0, 72'hABC, 144'd0, 0, "zero_a"};
    tv[5] = '{72'd1 << 54, 72'd1 << 18, 144'd1 << 72, 0, "limb3_x_limb1"};
    tv[6] = '{{72{1'b1}}, 72'd1, {72'd0, {72{1'b1}}}, 2, "max_x_one"};
    #12;
    chk("reset outputs", {result, out_valid, in_ready, busy}, {144'd0, 3'b010});
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) do_op(tv[i].a, tv[i].b, tv[i].exp, tv[i].hold, tv[i].name);

    // Asynchronous reset while cnt==4, then a fresh operation
    @(negedge clk);
    a_in = 72'd1234567;
    b_in = 72'd7654321;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #2;
    chk("busy before reset", 144'(busy), 144'd1);
    rst_n = 0;
    #1;
    chk("mid-op reset outputs", {result, out_valid, in_ready, busy}, {144'd0, 3'b010});
    @(negedge clk);
    rst_n = 1;
    do_op(72'd3, 72'd5, 144'd15, 0, "after_reset");

    // Flush at cnt==6 together with a new in_valid
    @(negedge clk);
    a_in = 72'd7;
    b_in = 72'd9;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    flush = 1;
    in_valid = 1;
    a_in = 72'd5;
    b_in = 72'd5;
    @(posedge clk);
    #1;
    chk("flush state", {141'd0, out_valid, in_ready, busy}, 144'b010);
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    chk("no activity after flush", 144'(seen), 144'd0);
    do_op(72'd1 << 71, 72'd2, 144'd1 << 72, 0, "after_flush");

    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom};
      if (i % 20 == 3) ra = {72{1'b1}};
      if (i % 20 == 7) rb = 72'd0;
      do_op(ra, rb, mul(ra, rb), $urandom_range(0, 3), "random");
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
